// File: rtl/pid_pkg.sv
// Shared definitions for the PID front end: ADC sequencer state encoding,
// timer status payload and counter sizing helper.
package pid_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    typedef logic [SEQ_STATE_W-1:0] seq_state_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_START   = 3'd1;
    localparam logic [2:0] ST_WAIT    = 3'd2;
    localparam logic [2:0] ST_HOLD    = 3'd3;
    localparam logic [2:0] ST_PUBLISH = 3'd4;
    localparam logic [2:0] ST_FAULT   = 3'd5;

    typedef struct packed {
        logic period_done;
        logic timeout;
    } timer_stat_t;

    // Bits for a counter spanning 0..n-1, never fewer than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 2) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sample_timer.sv
// Conversion period and ADC timeout counters for the sample sequencer.
module sample_timer
    import pid_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 100,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        load,
    input  logic        run,
    input  logic        tmo_run,
    output timer_stat_t stat_c
);

    localparam int unsigned PER_W = cnt_width(SAMPLE_DIV);
    localparam int unsigned TMO_W = cnt_width(TIMEOUT);

    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_DIV - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    logic [PER_W-1:0] per_cnt;
    logic [TMO_W-1:0] tmo_cnt;

    // Both counters read 0 during a START cycle; timeout saturates at its limit.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            per_cnt <= '0;
            tmo_cnt <= '0;
        end else if (clear || load) begin
            per_cnt <= '0;
            tmo_cnt <= '0;
        end else begin
            if (run) begin
                per_cnt <= per_cnt + PER_W'(1);
            end
            if (tmo_run && (tmo_cnt != TMO_LAST)) begin
                tmo_cnt <= tmo_cnt + TMO_W'(1);
            end
        end
    end

    always_comb begin
        stat_c             = '0;
        stat_c.period_done = (per_cnt == PER_LAST);
        stat_c.timeout     = (tmo_cnt == TMO_LAST);
    end

endmodule

// File: rtl/adc_sample_sequencer.sv
// Periodically triggers the ADC, averages 2^SR_LENGTH results and publishes
// the mean as cur_vd; a conversion that never completes latches fault.
module adc_sample_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = 8,
    parameter int unsigned SR_LENGTH  = 2,
    parameter int unsigned SAMPLE_DIV = 100,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 enable,
    input  logic                 adc_done,
    input  logic [ADC_WIDTH-1:0] adc_data,
    output logic                 adc_start,
    output logic [ADC_WIDTH-1:0] cur_vd,
    output logic                 vd_valid,
    output logic                 fault
);

    localparam int unsigned ACC_W     = ADC_WIDTH + SR_LENGTH;
    localparam int unsigned SCNT_W    = (SR_LENGTH > 1) ? SR_LENGTH : 1;
    localparam int unsigned N_SAMPLES = 1 << SR_LENGTH;

    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(N_SAMPLES - 1);

    seq_state_t        state_q;
    seq_state_t        state_nxt;
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_sum_c;
    logic [SCNT_W-1:0] scnt_q;
    logic              sample_take_c;
    logic              last_sample_c;
    timer_stat_t       tstat_c;
    logic              timer_load_c;
    logic              timer_run_c;
    logic              tmo_run_c;

    assign sample_take_c = enable && (state_q == ST_WAIT) && adc_done;
    assign last_sample_c = (scnt_q == LAST_SAMPLE);
    assign acc_sum_c     = acc_q + ACC_W'(adc_data);

    assign timer_load_c  = (state_nxt == ST_START);
    assign timer_run_c   = (state_q != ST_IDLE) && (state_q != ST_FAULT);
    assign tmo_run_c     = (state_q == ST_START) || (state_q == ST_WAIT);

    sample_timer #(
        .SAMPLE_DIV (SAMPLE_DIV),
        .TIMEOUT    (TIMEOUT)
    ) u_sample_timer (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (!enable),
        .load    (timer_load_c),
        .run     (timer_run_c),
        .tmo_run (tmo_run_c),
        .stat_c  (tstat_c)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Dropping enable wins from any state; a done in the timeout cycle still counts.
    always_comb begin
        state_nxt = state_q;
        if (!enable) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    state_nxt = ST_START;
                ST_START:   state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (adc_done) begin
                        state_nxt = last_sample_c ? ST_PUBLISH : ST_HOLD;
                    end else if (tstat_c.timeout) begin
                        state_nxt = ST_FAULT;
                    end
                end
                ST_HOLD: begin
                    if (tstat_c.period_done) begin
                        state_nxt = ST_START;
                    end
                end
                ST_PUBLISH: state_nxt = tstat_c.period_done ? ST_START : ST_HOLD;
                ST_FAULT:   state_nxt = ST_FAULT;
                default:    state_nxt = ST_IDLE;
            endcase
        end
    end

    // Outputs track the state being entered so each pulse aligns with its state.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            adc_start <= 1'b0;
            vd_valid  <= 1'b0;
            fault     <= 1'b0;
            cur_vd    <= '0;
            acc_q     <= '0;
            scnt_q    <= '0;
        end else begin
            adc_start <= (state_nxt == ST_START);
            vd_valid  <= (state_nxt == ST_PUBLISH);
            fault     <= (state_nxt == ST_FAULT);
            if (!enable || (state_q == ST_PUBLISH)) begin
                acc_q  <= '0;
                scnt_q <= '0;
            end else if (sample_take_c) begin
                acc_q  <= acc_sum_c;
                scnt_q <= scnt_q + SCNT_W'(1);
                if (last_sample_c) begin
                    cur_vd <= ADC_WIDTH'(acc_sum_c >> SR_LENGTH);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Randomized bench for adc_sample_sequencer against an event-level model of
// conversion timing, averaging and timeout behaviour (SR_LENGTH 2 and 0).
module tb_adc_sample_sequencer;

    localparam int unsigned ADC_WIDTH  = 8;
    localparam int unsigned SR_LENGTH  = 2;
    localparam int unsigned SAMPLE_DIV = 100;
    localparam int unsigned TIMEOUT    = 64;
    localparam int          N_AVG      = 1 << SR_LENGTH;
    localparam int          DIV        = int'(SAMPLE_DIV);
    localparam int          TMO        = int'(TIMEOUT);

    logic                 clk = 1'b0;
    logic                 n_rst;
    logic                 enable;
    logic                 adc_done;
    logic [ADC_WIDTH-1:0] adc_data;
    logic                 adc_start, vd_valid, fault;
    logic [ADC_WIDTH-1:0] cur_vd;
    logic                 adc_start0, vd_valid0, fault0;
    logic [ADC_WIDTH-1:0] cur_vd0;

    always #5 clk = ~clk;

    adc_sample_sequencer #(
        .ADC_WIDTH(ADC_WIDTH), .SR_LENGTH(SR_LENGTH),
        .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .n_rst(n_rst), .enable(enable), .adc_done(adc_done),
        .adc_data(adc_data), .adc_start(adc_start), .cur_vd(cur_vd),
        .vd_valid(vd_valid), .fault(fault)
    );

    adc_sample_sequencer #(
        .ADC_WIDTH(ADC_WIDTH), .SR_LENGTH(0),
        .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT)
    ) dut0 (
        .clk(clk), .n_rst(n_rst), .enable(enable), .adc_done(adc_done),
        .adc_data(adc_data), .adc_start(adc_start0), .cur_vd(cur_vd0),
        .vd_valid(vd_valid0), .fault(fault0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc;

    // Model state: session start, outstanding conversion, batch sum.
    bit sess, waiting, faulted;
    int fs, conv_start, nsamp, sum, resp_cyc;
    bit exp_start, exp_valid, exp_fault, exp_valid0;
    int exp_vd, exp_vd0;
    bit saw_valid;

    // Responder policy: 0 fixed delay, 1 never answers, 2 random mix.
    int resp_mode, fix_d;
    bit spur_en;
    int data_q[$];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic check_all();
        chk_eq("start",  32'(adc_start),  32'(exp_start));
        chk_eq("valid",  32'(vd_valid),   32'(exp_valid));
        chk_eq("fault",  32'(fault),      32'(exp_fault));
        chk_eq("vd",     32'(cur_vd),     32'(exp_vd));
        chk_eq("start0", 32'(adc_start0), 32'(exp_start));
        chk_eq("valid0", 32'(vd_valid0),  32'(exp_valid0));
        chk_eq("fault0", 32'(fault0),     32'(exp_fault));
        chk_eq("vd0",    32'(cur_vd0),    32'(exp_vd0));
        saw_valid = exp_valid;
    endtask

    task automatic model_reset();
        sess = 0; waiting = 0; faulted = 0; nsamp = 0; sum = 0;
        exp_start = 0; exp_valid = 0; exp_fault = 0; exp_valid0 = 0;
        exp_vd = 0; exp_vd0 = 0;
    endtask

    function automatic int plan_response(input int s);
        int r;
        if (resp_mode == 0) return s + fix_d;
        if (resp_mode == 1) return -1;
        r = int'($urandom_range(0, 99));
        if (r < 4)  return -1;
        if (r < 7)  return s;
        if (r < 10) return s + TMO;
        if (r < 25) return s + TMO - 1;
        return s + int'($urandom_range(1, TIMEOUT - 2));
    endfunction

    // Drive this cycle's ADC inputs and predict the outputs after the next edge.
    task automatic advance();
        adc_done = 1'b0;
        adc_data = ADC_WIDTH'($urandom);
        if (cyc == resp_cyc) begin
            adc_done = 1'b1;
            if (data_q.size() > 0) adc_data = ADC_WIDTH'(data_q.pop_front());
        end else if (spur_en && !waiting && $urandom_range(0, 15) == 0) begin
            adc_done = 1'b1;
        end
        exp_start = 0; exp_valid = 0; exp_valid0 = 0;
        if (!enable) begin
            sess = 0; waiting = 0; faulted = 0; nsamp = 0; sum = 0;
        end else if (!sess) begin
            sess = 1; fs = cyc + 1;
        end else if (waiting && adc_done && cyc > conv_start) begin
            waiting = 0;
            sum += int'(adc_data);
            nsamp++;
            exp_valid0 = 1; exp_vd0 = int'(adc_data);
            if (nsamp == N_AVG) begin
                exp_valid = 1; exp_vd = sum / N_AVG; sum = 0; nsamp = 0;
            end
        end else if (waiting && (cyc - conv_start) == TMO - 1) begin
            waiting = 0; faulted = 1;
        end
        if (sess && !faulted && ((cyc + 1 - fs) % DIV) == 0) begin
            exp_start = 1; conv_start = cyc + 1; waiting = 1;
            resp_cyc = plan_response(cyc + 1);
        end
        exp_fault = faulted;
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            advance(); tick();
        end
    endtask

    task automatic run_until_valid(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 5 * DIV && !seen; i++) begin
            advance(); tick(); seen = saw_valid;
        end
        chk_eq(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit reached;
        int vd_hold;
        n_rst = 0; enable = 0; adc_done = 0; adc_data = '0;
        resp_cyc = -1; resp_mode = 0; fix_d = 5; spur_en = 0; cyc = 0;
        model_reset();
        @(posedge clk); #1;
        check_all();
        n_rst = 1;

        // Ramp, full-scale and truncation batches with a 5-cycle ADC.
        enable = 1;
        data_q = '{10, 11, 12, 13, 255, 255, 255, 255, 0, 0, 0, 3};
        run_until_valid("pub_ramp");
        chk_eq("avg_ramp", 32'(cur_vd), 32'd11);
        run_until_valid("pub_full");
        chk_eq("avg_full", 32'(cur_vd), 32'd255);
        run_until_valid("pub_trunc");
        chk_eq("avg_trunc", 32'(cur_vd), 32'd0);
        chk_eq("vd0_trunc", 32'(cur_vd0), 32'd3);

        // ADC never answers: sticky fault, recovery through enable.
        resp_mode = 1;
        reached = 0;
        for (int i = 0; i < 3 * DIV && !reached; i++) begin
            advance(); tick(); reached = faulted;
        end
        chk_eq("reach_fault", 32'(reached), 32'd1);
        run(2 * DIV);
        chk_eq("fault_sticky", 32'(fault), 32'd1);
        enable = 0;
        run(3);
        chk_eq("fault_clear", 32'(fault), 32'd0);
        enable = 1; resp_mode = 0; fix_d = 7;
        run_until_valid("pub_recover");

        // Done in the last allowed cycle is accepted.
        fix_d = TMO - 1;
        run_until_valid("pub_edge");
        chk_eq("fault_edge", 32'(fault), 32'd0);

        // Enable dropped mid-batch: partial samples are discarded.
        fix_d = 3;
        data_q = '{200, 200};
        reached = 0;
        for (int i = 0; i < 3 * DIV && !reached; i++) begin
            advance(); tick(); reached = (nsamp == 2);
        end
        chk_eq("reach_half", 32'(reached), 32'd1);
        vd_hold = exp_vd;
        enable = 0;
        run(5);
        chk_eq("vd_hold", 32'(cur_vd), 32'(vd_hold));
        data_q = '{40, 41, 42, 43};
        enable = 1;
        run_until_valid("pub_fresh");
        chk_eq("avg_fresh", 32'(cur_vd), 32'd41);

        // Reset in the middle of a conversion; its late done must be ignored.
        fix_d = 20;
        reached = 0;
        for (int i = 0; i < 3 * DIV && !reached; i++) begin
            advance(); tick(); reached = waiting && (cyc - conv_start >= 10);
        end
        chk_eq("reach_mid_conv", 32'(reached), 32'd1);
        n_rst = 0; enable = 0;
        #1;
        model_reset();
        check_all();
        @(posedge clk); #1;
        cyc++;
        check_all();
        n_rst = 1;
        run(20);
        data_q = '{1, 2, 3, 4};
        enable = 1;
        run_until_valid("pub_after_rst");
        chk_eq("avg_after_rst", 32'(cur_vd), 32'd2);
        chk_eq("vd0_after_rst", 32'(cur_vd0), 32'd4);

        // Random ADC latencies, spurious dones and enable drops.
        resp_mode = 2; spur_en = 1;
        for (int i = 0; i < 6000; i++) begin
            if (enable) begin
                if ($urandom_range(0, faulted ? 40 : 500) == 0) enable = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                enable = 1;
            end
            advance(); tick();
        end
        enable = 0;
        run(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
